// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: edge-detected start/stop/clear commands, run limit and command lockout.
// Optional lap capture is compiled in with STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
  parameter int unsigned RUN_LIMIT = 1000,
  parameter int unsigned HOLDOFF   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
  output logic        lap_strobe,
  output logic [15:0] lap_val,
`endif
  output logic        en,
  output logic        rst,
  output logic        done,
  output logic [2:0]  state,
  output logic [15:0] run_cnt
);

  typedef enum logic [2:0] {
    StClr   = 3'd0,
    StIdle  = 3'd1,
    StRun   = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [15:0] Limit    = 16'(RUN_LIMIT);
  localparam logic [15:0] LimitM1  = 16'(RUN_LIMIT - 1);
  localparam logic [15:0] HoldLoad = 16'(HOLDOFF);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] hold_q, hold_d;
  logic        start_q, stop_q, clear_q;
  logic        start_edge, stop_edge, clear_edge, hold_free;

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop & ~stop_q;
  assign clear_edge = clear & ~clear_q;
  assign hold_free  = (hold_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (state_q == StRun && cnt_q != Limit) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (!hold_free) begin
      hold_d = hold_q - 16'd1;
    end
    // Priority: clear > limit > stop > start.
    if (clear_edge) begin
      state_d = StClr;
      cnt_d   = 16'd0;
      hold_d  = 16'd0;
    end else if (state_q == StRun && cnt_q == LimitM1) begin
      state_d = StDone;
    end else begin
      case (state_q)
        StClr:   state_d = StIdle;
        StIdle, StPause: begin
          if (start_edge && hold_free) begin
            state_d = StRun;
            hold_d  = HoldLoad;
          end
        end
        StRun: begin
          if (stop_edge && hold_free) begin
            state_d = StPause;
            hold_d  = HoldLoad;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StClr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StClr;
      cnt_q   <= 16'd0;
      hold_q  <= 16'd0;
      start_q <= start;
      stop_q  <= stop;
      clear_q <= clear;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      start_q <= start;
      stop_q  <= stop;
      clear_q <= clear;
    end
  end

  always_comb begin
    en      = 1'b0;
    rst     = 1'b0;
    done    = 1'b0;
    state   = state_q;
    run_cnt = cnt_q;
    case (state_q)
      StClr:   rst  = 1'b1;
      StRun:   en   = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_q, lap_edge;
  logic        lap_strobe_q, lap_strobe_d;
  logic [15:0] lap_val_q, lap_val_d;

  assign lap_edge = lap & ~lap_q;

  // Laps bypass the holdoff lockout and never load it.
  always_comb begin
    lap_strobe_d = 1'b0;
    lap_val_d    = lap_val_q;
    if (clear_edge) begin
      lap_val_d = 16'd0;
    end else if (lap_edge && state_q == StRun) begin
      lap_val_d    = cnt_q;
      lap_strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q        <= lap;
      lap_strobe_q <= 1'b0;
      lap_val_q    <= 16'd0;
    end else begin
      lap_q        <= lap;
      lap_strobe_q <= lap_strobe_d;
      lap_val_q    <= lap_val_d;
    end
  end

  assign lap_strobe = lap_strobe_q;
  assign lap_val    = lap_val_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with RUN_LIMIT=10, HOLDOFF=3; lap checks when STOPWATCH_LAP_EN is set.
module tb_stopwatch_ctrl;

  localparam int unsigned RunLimit = 10;
  localparam int unsigned Holdoff  = 3;
  localparam int unsigned NumVecs  = 20;

  logic        clk = 1'b0;
  logic        reset, start, stop, clear, lap;
  logic        en, rst, done;
  logic [2:0]  state;
  logic [15:0] run_cnt;
`ifdef STOPWATCH_LAP_EN
  logic        lap_strobe;
  logic [15:0] lap_val;
`endif

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .RUN_LIMIT(RunLimit),
    .HOLDOFF  (Holdoff)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
`ifdef STOPWATCH_LAP_EN
    .lap       (lap),
    .lap_strobe(lap_strobe),
    .lap_val   (lap_val),
`endif
    .en        (en),
    .rst       (rst),
    .done      (done),
    .state     (state),
    .run_cnt   (run_cnt)
  );

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic        en;
    logic        rst;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic s;
    logic p;
    logic c;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NumVecs];
  int   checks   = 0;
  int   failures = 0;
  int   en_cycles;

  // Expected outputs from the state encoding: CLR=0 IDLE=1 RUN=2 PAUSE=3 DONE=4.
  function automatic exp_t mk(input string n, input logic [2:0] st, input logic [15:0] cnt);
    exp_t e;
    e.name = n;
    e.st   = st;
    e.en   = (st == 3'd2);
    e.rst  = (st == 3'd0);
    e.done = (st == 3'd4);
    e.cnt  = cnt;
    return e;
  endfunction

  task automatic set_vec(input int i, input logic s, input logic p, input logic c,
                         input string n, input logic [2:0] st, input logic [15:0] cnt);
    vecs[i].s = s;
    vecs[i].p = p;
    vecs[i].c = c;
    vecs[i].e = mk(n, st, cnt);
  endtask

  task automatic tick(input logic s, input logic p, input logic c);
    start = s;
    stop  = p;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pop();
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (state !== e.st || en !== e.en || rst !== e.rst || done !== e.done || run_cnt !== e.cnt)
    begin
      failures++;
      $display("FAIL %s: got state=%0d en=%0b rst=%0b done=%0b run_cnt=%0d, want state=%0d en=%0b rst=%0b done=%0b run_cnt=%0d",
               e.name, state, en, rst, done, run_cnt, e.st, e.en, e.rst, e.done, e.cnt);
    end
  endtask

  task automatic step(input logic s, input logic p, input logic c,
                      input string n, input logic [2:0] st, input logic [15:0] cnt);
    sb.push_back(mk(n, st, cnt));
    tick(s, p, c);
    check_pop();
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic check_lap(input string n, input logic want_strobe, input logic [15:0] want_val);
    checks++;
    if (lap_strobe !== want_strobe || lap_val !== want_val) begin
      failures++;
      $display("FAIL %s: got lap_strobe=%0b lap_val=%0d, want lap_strobe=%0b lap_val=%0d",
               n, lap_strobe, lap_val, want_strobe, want_val);
    end
  endtask
`endif

  initial begin
    // Start, holdoff-dropped stop, accepted stop, resume, limit, DONE stickiness, clear.
    set_vec(0,  1, 0, 0, "t_start",          3'd2, 16'd0);
    set_vec(1,  1, 0, 0, "t_run1",           3'd2, 16'd1);
    set_vec(2,  0, 1, 0, "t_stop_dropped",   3'd2, 16'd2);
    set_vec(3,  0, 0, 0, "t_run3",           3'd2, 16'd3);
    set_vec(4,  0, 1, 0, "t_stop_taken",     3'd3, 16'd4);
    set_vec(5,  0, 0, 0, "t_pause1",         3'd3, 16'd4);
    set_vec(6,  0, 0, 0, "t_pause2",         3'd3, 16'd4);
    set_vec(7,  0, 0, 0, "t_pause3",         3'd3, 16'd4);
    set_vec(8,  1, 0, 0, "t_resume",         3'd2, 16'd4);
    set_vec(9,  0, 0, 0, "t_run5",           3'd2, 16'd5);
    set_vec(10, 0, 0, 0, "t_run6",           3'd2, 16'd6);
    set_vec(11, 0, 0, 0, "t_run7",           3'd2, 16'd7);
    set_vec(12, 0, 0, 0, "t_run8",           3'd2, 16'd8);
    set_vec(13, 0, 0, 0, "t_run9",           3'd2, 16'd9);
    set_vec(14, 0, 0, 0, "t_limit",          3'd4, 16'd10);
    set_vec(15, 1, 0, 0, "t_start_in_done",  3'd4, 16'd10);
    set_vec(16, 0, 1, 0, "t_stop_in_done",   3'd4, 16'd10);
    set_vec(17, 0, 0, 1, "t_clear",          3'd0, 16'd0);
    set_vec(18, 0, 0, 1, "t_clear_held",     3'd1, 16'd0);
    set_vec(19, 0, 0, 0, "t_idle",           3'd1, 16'd0);

    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
    lap   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk("reset_clr", 3'd0, 16'd0));
    check_pop();
    reset = 1'b0;
    step(0, 0, 0, "reset_idle", 3'd1, 16'd0);
    step(0, 0, 0, "idle_hold",  3'd1, 16'd0);

    for (int i = 0; i < int'(NumVecs); i++) begin
      sb.push_back(vecs[i].e);
      tick(vecs[i].s, vecs[i].p, vecs[i].c);
      check_pop();
    end

    // Uninterrupted run must give exactly RunLimit en-high cycles.
    step(1, 0, 0, "a_start", 3'd2, 16'd0);
    en_cycles = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      tick(0, 0, 0);
      if (en) en_cycles++;
    end
    checks++;
    if (en_cycles != int'(RunLimit) || done !== 1'b1) begin
      failures++;
      $display("FAIL a_en_cycles: got en_cycles=%0d done=%0b, want en_cycles=%0d done=1",
               en_cycles, done, RunLimit);
    end
    step(0, 0, 0, "a_done_hold1", 3'd4, 16'd10);
    step(0, 0, 0, "a_done_hold2", 3'd4, 16'd10);
    step(0, 0, 1, "a_clear",      3'd0, 16'd0);
    step(0, 0, 0, "a_idle",       3'd1, 16'd0);

    // Start+stop+clear together in PAUSE: clear wins.
    step(1, 0, 0, "b_start",    3'd2, 16'd0);
    step(0, 0, 0, "b_run1",     3'd2, 16'd1);
    step(0, 0, 0, "b_run2",     3'd2, 16'd2);
    step(0, 0, 0, "b_run3",     3'd2, 16'd3);
    step(0, 1, 0, "b_pause",    3'd3, 16'd4);
    step(0, 0, 0, "b_pause2",   3'd3, 16'd4);
    step(1, 1, 1, "b_all_edges", 3'd0, 16'd0);
    step(0, 0, 0, "b_idle",     3'd1, 16'd0);

    // Run to 7 (lap at 5), then reset mid-run with start held high.
    step(1, 0, 0, "c_start", 3'd2, 16'd0);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, "c_run", 3'd2, 16'(i));
    end
    lap = 1'b1;
    step(1, 0, 0, "c_lap_run6", 3'd2, 16'd6);
`ifdef STOPWATCH_LAP_EN
    check_lap("lap_capture", 1'b1, 16'd5);
`endif
    step(1, 0, 0, "c_lap_run7", 3'd2, 16'd7);
`ifdef STOPWATCH_LAP_EN
    check_lap("lap_strobe_end", 1'b0, 16'd5);
`endif
    reset = 1'b1;
    step(1, 0, 0, "c_reset_clr", 3'd0, 16'd0);
    reset = 1'b0;
    step(1, 0, 0, "c_reset_idle", 3'd1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, "c_no_restart", 3'd1, 16'd0);
    end
`ifdef STOPWATCH_LAP_EN
    check_lap("lap_after_reset", 1'b0, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter line: RUN_LIMIT, default 1000, number of en-high cycles before automatic stop; legal range 1..65535.
REQ-002 Parameter line: HOLDOFF, default 3, number of cycles after an accepted start/stop during which start/stop edges are dropped; 0 disables the lockout.
REQ-003 Port line: clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 Port line: reset  in  1  synchronous, active-high reset.
REQ-005 Port line: start  in  1  level input; its rising edge is the start/resume command.
REQ-006 Port line: stop  in  1  level input; its rising edge is the pause command.
REQ-007 Port line: clear  in  1  level input; its rising edge is the clear command.
REQ-008 Port line: en  out  1  count enable to the counter datapath.
REQ-009 Port line: rst  out  1  one-cycle clear pulse to the counter datapath.
REQ-010 Port line: done  out  1  high while in DONE.
REQ-011 Port line: state  out  3  encoding: CLR=0, IDLE=1, RUN=2, PAUSE=3, DONE=4.
REQ-012 Port line: run_cnt  out  16  count of en-high cycles since the last clear.

Function
REQ-013 Rising-edge detection SHALL use one registered copy per command input; an edge is input=1 with the registered copy=0 at a posedge.
REQ-014 All outputs SHALL be registered Moore outputs decoded from the state register; command latency is 1 cycle (state/en change is visible after the same edge that samples the edge).
REQ-015 The output decode SHALL be: CLR: rst=1, en=0. IDLE: rst=0, en=0. RUN: rst=0, en=1. PAUSE: rst=0, en=0. DONE: rst=0, en=0, done=1.
REQ-016 CLR SHALL last exactly 1 cycle, then go to IDLE unconditionally unless a new clear edge is sampled.
REQ-017 A clear edge in any state SHALL go to CLR, zero run_cnt and zero the holdoff counter, regardless of holdoff.
REQ-018 A start edge in IDLE or PAUSE SHALL go to RUN; in RUN, DONE or CLR it SHALL be ignored.
REQ-019 A stop edge in RUN SHALL go to PAUSE; in other states it SHALL be ignored.
REQ-020 Simultaneous edges SHALL resolve with priority clear > limit > stop > start.
REQ-021 run_cnt SHALL increment at every edge where state==RUN and SHALL saturate at RUN_LIMIT.
REQ-022 When state==RUN and run_cnt==RUN_LIMIT-1 at an edge, run_cnt SHALL become RUN_LIMIT and the state SHALL become DONE, giving exactly RUN_LIMIT en-high cycles.
REQ-023 DONE SHALL be left only by a clear edge or by reset.
REQ-024 An accepted start or stop SHALL load the holdoff counter with HOLDOFF.
REQ-025 While the holdoff counter is nonzero, it SHALL decrement each cycle, and start/stop edges SHALL be dropped, not queued.

Reset
REQ-026 While reset=1 at a posedge, the block SHALL set state=CLR, run_cnt=0, the holdoff counter=0, the edge registers=current inputs, and the lap registers=0.
REQ-027 Consequently, in the first cycle after reset the outputs SHALL be rst=1, en=0, done=0, and the next cycle SHALL be IDLE.
REQ-028 Reset mid-RUN SHALL abort the run with no pause state retained.
REQ-029 Inputs held high through reset SHALL NOT produce an edge after reset.

Configuration
REQ-030 The macro STOPWATCH_LAP_EN SHALL compile in the lap feature.
REQ-031 With STOPWATCH_LAP_EN defined, the block SHALL add these ports: lap in 1; lap_strobe out 1; lap_val out 16.
REQ-032 With STOPWATCH_LAP_EN defined, a lap edge in RUN SHALL capture run_cnt into lap_val and pulse lap_strobe for 1 cycle.
REQ-033 With STOPWATCH_LAP_EN defined, lap edges SHALL ignore holdoff, SHALL NOT load it, and SHALL be ignored outside RUN.
REQ-034 With STOPWATCH_LAP_EN defined, a clear edge SHALL zero lap_val.
REQ-035 Without STOPWATCH_LAP_EN, the lap, lap_strobe and lap_val ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset, then idle: the bench SHALL check rst=1 for 1 cycle, then state=1, with en=0 and run_cnt=0.
REQ-037 RUN_LIMIT=10, start edge, no other input: the bench SHALL check en=1 for exactly 10 cycles, then done=1, state=4 and run_cnt=10 held.
REQ-038 HOLDOFF=3, start edge, then a stop edge 2 cycles later: the bench SHALL check that the stop is dropped and the state stays RUN; a stop edge 4 cycles after start SHALL give PAUSE.
REQ-039 Start, stop and clear edges in the same cycle while in PAUSE: the bench SHALL check state=CLR, then IDLE, with run_cnt=0.
REQ-040 STOPWATCH_LAP_EN defined, lap edge while run_cnt=5: the bench SHALL check lap_val=5 and lap_strobe high for 1 cycle, with counting uninterrupted.
REQ-041 Reset asserted while in RUN with run_cnt=7: the bench SHALL check state=CLR, then IDLE, with run_cnt=0 and start held high causing no restart.
